// File: rtl/bid_log_pkg.sv
// Shared types for the bid round logger: winner/state enums, error codes
// and the packed result record carried through the result FIFO.
package bid_log_pkg;

  localparam int REC_RID_W = 16;
  localparam int REC_AMT_W = 32;
  localparam int TS_W      = 32;

  localparam logic [2:0] ERR_NONE      = 3'b000;
  localparam logic [2:0] ERR_DUPLICATE = 3'b101;

  typedef enum logic [1:0] {
    W_NONE = 2'b00,
    W_X    = 2'b01,
    W_Y    = 2'b10,
    W_Z    = 2'b11
  } winner_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DECODE = 2'b01,
    COMMIT = 2'b10
  } log_state_e;

  typedef struct packed {
    logic [REC_RID_W-1:0] round_id;
    winner_e              winner;
    logic [REC_AMT_W-1:0] amount;
    logic [2:0]           err;
    logic [TS_W-1:0]      timestamp;
  } result_rec_t;

  // win bits are {Z, Y, X}; anything but a single bit maps to none
  function automatic winner_e enc_winner(input logic [2:0] w);
    winner_e v;
    case (w)
      3'b001:  v = W_X;
      3'b010:  v = W_Y;
      3'b100:  v = W_Z;
      default: v = W_NONE;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/bid_round_logger_if.sv
// Result read port of the bid round logger: head record plus
// valid/ready handshake. Master is the logger, slave the consumer.
interface bid_round_logger_if
  import bid_log_pkg::*;
#(
  parameter int RID_W = REC_RID_W,
  parameter int AMT_W = REC_AMT_W
);

  logic             rd_valid;
  logic             rd_ready;
  logic [RID_W-1:0] rd_round_id;
  logic [1:0]       rd_winner;
  logic [AMT_W-1:0] rd_amount;
  logic [2:0]       rd_err;
  logic [TS_W-1:0]  rd_timestamp;

  modport master (
    output rd_valid,
    output rd_round_id,
    output rd_winner,
    output rd_amount,
    output rd_err,
    output rd_timestamp,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_round_id,
    input  rd_winner,
    input  rd_amount,
    input  rd_err,
    input  rd_timestamp,
    output rd_ready
  );

endinterface

// File: rtl/bid_log_fifo.sv
// Synchronous FIFO of typed records; a push is still taken when full
// as long as a pop happens in the same cycle.
module bid_log_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  T     i_wdata,
  input  logic i_pop,
  output T     o_rdata,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  T           r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_push;
  logic        w_pop;

  // extra pointer msb separates full from empty
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/bid_round_logger.sv
// Logs one result record per arbitration round into a FIFO and keeps
// win/revenue statistics. Define BID_LOG_TIMESTAMP_EN to stamp records.
module bid_round_logger
  import bid_log_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AMT_W = REC_AMT_W,
  parameter int RID_W = REC_RID_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             roundOver,
  input  logic             X_win,
  input  logic             Y_win,
  input  logic             Z_win,
  input  logic [AMT_W-1:0] maxBid,
  input  logic [2:0]       err,
  input  logic             stats_clr,
  bid_round_logger_if.master rd,
  output logic [CNT_W-1:0] x_wins,
  output logic [CNT_W-1:0] y_wins,
  output logic [CNT_W-1:0] z_wins,
  output logic [AMT_W-1:0] revenue,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             proto_err,
  output logic             fifo_full,
  output logic             fifo_empty
);

  log_state_e       r_state;
  logic             r_ro_q;
  logic [2:0]       r_win;
  logic [AMT_W-1:0] r_amt;
  logic [2:0]       r_err;
  winner_e          r_winner;
  logic [AMT_W-1:0] r_rec_amt;
  logic [RID_W-1:0] r_rid;

  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic [CNT_W-1:0] r_z;
  logic [AMT_W-1:0] r_rev;
  logic [CNT_W-1:0] r_drop;
  logic             r_perr;

  logic             w_evt;
  logic             w_commit;
  logic             w_pop;
  logic             w_accept;
  logic             w_full;
  logic             w_empty;
  logic             w_multi;
  logic             w_busy_evt;
  logic [AMT_W:0]   w_rev_sum;
  logic [TS_W-1:0]  w_ts;
  result_rec_t      w_wrec;
  result_rec_t      w_head;

  assign w_evt      = roundOver & ~r_ro_q;
  assign w_commit   = (r_state == COMMIT);
  assign w_pop      = ~w_empty & rd.rd_ready;
  assign w_accept   = ~w_full | w_pop;
  assign w_multi    = (r_state == DECODE) & ~$onehot0(r_win);
  assign w_busy_evt = w_evt & (r_state != IDLE);
  assign w_rev_sum  = {1'b0, r_rev} + {1'b0, r_rec_amt};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ro_q    <= 1'b0;
      r_win     <= '0;
      r_amt     <= '0;
      r_err     <= ERR_NONE;
      r_winner  <= W_NONE;
      r_rec_amt <= '0;
      r_rid     <= '0;
    end else begin
      r_ro_q <= roundOver;
      unique case (r_state)
        IDLE: begin
          if (w_evt) begin
            r_win   <= {Z_win, Y_win, X_win};
            r_amt   <= maxBid;
            r_err   <= err;
            r_state <= DECODE;
          end
        end
        DECODE: begin
          if ($onehot(r_win) && r_err != ERR_DUPLICATE) begin
            r_winner  <= enc_winner(r_win);
            r_rec_amt <= r_amt;
          end else begin
            r_winner  <= W_NONE;
            r_rec_amt <= '0;
          end
          r_state <= COMMIT;
        end
        COMMIT: begin
          // dropped rounds still consume an id
          r_rid   <= r_rid + RID_W'(1);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_rev  <= '0;
      r_drop <= '0;
      r_perr <= 1'b0;
    end else begin
      if (w_commit && w_accept) begin
        unique case (r_winner)
          W_X: if (r_x != '1) r_x <= r_x + CNT_W'(1);
          W_Y: if (r_y != '1) r_y <= r_y + CNT_W'(1);
          W_Z: if (r_z != '1) r_z <= r_z + CNT_W'(1);
          default: ;
        endcase
        r_rev <= w_rev_sum[AMT_W] ? '1 : w_rev_sum[AMT_W-1:0];
      end
      if (w_commit && !w_accept && r_drop != '1)
        r_drop <= r_drop + CNT_W'(1);
      if (w_multi || w_busy_evt)
        r_perr <= 1'b1;
    end
  end

`ifdef BID_LOG_TIMESTAMP_EN
  logic [TS_W-1:0] r_cyc;
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc <= '0;
      r_ts  <= '0;
    end else begin
      r_cyc <= r_cyc + TS_W'(1);
      if (r_state == IDLE && w_evt) r_ts <= r_cyc;
    end
  end

  assign w_ts = r_ts;
`else
  assign w_ts = '0;
`endif

  always_comb begin
    w_wrec           = '0;
    w_wrec.round_id  = r_rid;
    w_wrec.winner    = r_winner;
    w_wrec.amount    = r_rec_amt;
    w_wrec.err       = r_err;
    w_wrec.timestamp = w_ts;
  end

  bid_log_fifo #(
    .DEPTH (DEPTH),
    .T     (result_rec_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_commit),
    .i_wdata (w_wrec),
    .i_pop   (rd.rd_ready),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // head fields read as zero while the FIFO is empty
  assign rd.rd_valid     = ~w_empty;
  assign rd.rd_round_id  = w_empty ? '0 : w_head.round_id;
  assign rd.rd_winner    = w_empty ? '0 : w_head.winner;
  assign rd.rd_amount    = w_empty ? '0 : w_head.amount;
  assign rd.rd_err       = w_empty ? '0 : w_head.err;
  assign rd.rd_timestamp = w_empty ? '0 : w_head.timestamp;

  assign x_wins     = r_x;
  assign y_wins     = r_y;
  assign z_wins     = r_z;
  assign revenue    = r_rev;
  assign drop_cnt   = r_drop;
  assign proto_err  = r_perr;
  assign fifo_full  = w_full;
  assign fifo_empty = w_empty;

endmodule

// File: doc/bid_round_logger.md
Name: bid_round_logger

Overview:
- Downstream consumer of the bid arbitration core's result outputs (roundOver, X_win/Y_win/Z_win, maxBid, err).
- Detects each round completion, encodes the winner, and pushes one result record per round into a small FIFO drained over a valid/ready handshake.
- Keeps per-bidder win counters and a saturating revenue total for host/testbench readback.

Parameters:
- DEPTH, 8, result FIFO depth; power of two, 2..64.
- AMT_W, 32, width of maxBid and the revenue accumulator.
- RID_W, 16, round-id width; wraps modulo 2^RID_W.
- CNT_W, 16, per-bidder win-counter width; saturating.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- roundOver  in  1  round-complete strobe from the arbitration core.
- X_win  in  1  X won, valid while roundOver=1.
- Y_win  in  1  Y won, valid while roundOver=1.
- Z_win  in  1  Z won, valid while roundOver=1.
- maxBid  in  AMT_W  winning amount, valid while roundOver=1.
- err  in  3  core error code, valid while roundOver=1.
- stats_clr  in  1  clears counters and sticky flags; FIFO is untouched.
- rd_ready  in  1  consumer accepts the head record.
- rd_valid  out  1  head record valid.
- rd_round_id  out  RID_W  round number.
- rd_winner  out  2  encoding: 00 none, 01 X, 10 Y, 11 Z.
- rd_amount  out  AMT_W  maxBid, or 0 when the winner is none.
- rd_err  out  3  captured err.
- rd_timestamp  out  32  capture cycle stamp (see Optional Feature).
- x_wins  out  CNT_W  X win count.
- y_wins  out  CNT_W  Y win count.
- z_wins  out  CNT_W  Z win count.
- revenue  out  AMT_W  saturating sum of winning amounts.
- drop_cnt  out  CNT_W  records dropped because the FIFO was full; saturating.
- proto_err  out  1  sticky protocol-error flag.
- fifo_full  out  1  FIFO full.
- fifo_empty  out  1  FIFO empty.

Behaviour:
- Reset: every output 0 except fifo_empty=1; FSM returns to IDLE; next round id 0; roundOver history register 0. Reset mid-operation discards any in-flight record.
- Edge detect: round_evt = roundOver & ~roundOver_q.
- FSM states IDLE, DECODE, COMMIT.
  - IDLE: on round_evt, register win bits, maxBid, err; go to DECODE.
  - DECODE: compute winner from the registered bits.
    - Exactly one bit set: winner = that bidder.
    - No bits set, or err=3'b101 (duplicate): winner none, amount 0.
    - More than one bit set: winner none, amount 0, set proto_err.
    - Go to COMMIT.
  - COMMIT: push the record; update counters; increment round id; go to IDLE.
- Latency: round_evt in cycle N gives rd_valid=1 in cycle N+3 when the FIFO was empty.
- round_evt while in DECODE or COMMIT: event ignored, proto_err set.
- Round id increments on every committed or dropped round and wraps from 2^RID_W-1 to 0.
- Counters update only when the record is accepted:
  - winner-specific win counter +1, saturating at all-ones;
  - revenue += amount, saturating at 2^AMT_W-1 with no wrap.
- FIFO full at COMMIT with no pop in the same cycle: record dropped, counters unchanged, drop_cnt +1, proto_err unaffected.
- Full with a simultaneous pop (rd_valid & rd_ready): push accepted and occupancy unchanged.
- Handshake: rd_* reflects the FIFO head combinationally.
  - Pop occurs when rd_valid & rd_ready.
  - Head is stable while rd_valid=1 and rd_ready=0.
  - rd_ready while empty has no effect.
- stats_clr: next cycle x_wins/y_wins/z_wins/revenue/drop_cnt/proto_err = 0.
  - If stats_clr coincides with COMMIT, clear wins; counters = 0.
  - Round id is not cleared.

Optional Feature:
- Macro BID_LOG_TIMESTAMP_EN.
- Defined: a free-running 32-bit cycle counter, reset to 0 and wrapping. Its value at the round_evt cycle is stored in the record and presented on rd_timestamp.
- Undefined: no counter and no timestamp storage; rd_timestamp is tied to 0.

Decomposition:
- Package bid_log_pkg holds:
  - winner_e enum (W_NONE, W_X, W_Y, W_Z);
  - log_state_e enum (IDLE, DECODE, COMMIT);
  - err constants ERR_DUPLICATE=3'b101 and ERR_NONE=3'b000;
  - a packed result_rec_t struct (round_id, winner, amount, err, timestamp).
- Sub-module bid_log_fifo: synchronous FIFO parameterised by DEPTH and record type, providing full/empty flags and simultaneous push/pop at full.

Test Plan:
- After reset: roundOver=1 for one cycle with Y_win=1, maxBid=32'd500, err=0 → 3 cycles later rd_valid=1, round_id=0, winner=10, amount=500; y_wins=1, revenue=500.
- err=3'b101, no win bits, maxBid=32'd77 → winner=00, amount=0, rd_err=101; win counters and revenue unchanged.
- 9 X-win rounds with rd_ready=0 and DEPTH=8 → fifo_full=1, drop_cnt=1, x_wins=8; the 9th round's id=8 is absent; drain order returns ids 0..7.
- FIFO full, rd_ready=1 during the COMMIT cycle → occupancy stays 8 and no drop occurs.
- revenue preloaded near max via rounds of maxBid=32'hFFFF_FFF0, then 32'h20 → revenue=32'hFFFF_FFFF, with no wrap.
- X_win=Y_win=1 → proto_err=1, winner=00; then stats_clr=1 → proto_err=0, counters 0, and the next round id continues from where it was.
